// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_ctrl_pkg
//  Description : Shared encodings for the five-stage MIPS pipeline controller.
//                Opcode/funct/rt constants, select-field encodings, the
//                per-instruction control bundle and the forwarding picker.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_ctrl_pkg;

    // Primary opcodes
    localparam logic [5:0] C_OP_SPECIAL = 6'h00;
    localparam logic [5:0] C_OP_REGIMM  = 6'h01;
    localparam logic [5:0] C_OP_J       = 6'h02;
    localparam logic [5:0] C_OP_JAL     = 6'h03;
    localparam logic [5:0] C_OP_BEQ     = 6'h04;
    localparam logic [5:0] C_OP_BNE     = 6'h05;
    localparam logic [5:0] C_OP_ADDI    = 6'h08;
    localparam logic [5:0] C_OP_ADDIU   = 6'h09;
    localparam logic [5:0] C_OP_ORI     = 6'h0d;
    localparam logic [5:0] C_OP_LUI     = 6'h0f;
    localparam logic [5:0] C_OP_LW      = 6'h23;
    localparam logic [5:0] C_OP_SW      = 6'h2b;

    // SPECIAL funct codes
    localparam logic [5:0] C_FN_SLL   = 6'h00;
    localparam logic [5:0] C_FN_SRL   = 6'h02;
    localparam logic [5:0] C_FN_JR    = 6'h08;
    localparam logic [5:0] C_FN_MOVZ  = 6'h0a;
    localparam logic [5:0] C_FN_MFHI  = 6'h10;
    localparam logic [5:0] C_FN_MTHI  = 6'h11;
    localparam logic [5:0] C_FN_MFLO  = 6'h12;
    localparam logic [5:0] C_FN_MTLO  = 6'h13;
    localparam logic [5:0] C_FN_MULT  = 6'h18;
    localparam logic [5:0] C_FN_MULTU = 6'h19;
    localparam logic [5:0] C_FN_DIV   = 6'h1a;
    localparam logic [5:0] C_FN_DIVU  = 6'h1b;
    localparam logic [5:0] C_FN_ADD   = 6'h20;
    localparam logic [5:0] C_FN_ADDU  = 6'h21;
    localparam logic [5:0] C_FN_SUB   = 6'h22;
    localparam logic [5:0] C_FN_SUBU  = 6'h23;
    localparam logic [5:0] C_FN_AND   = 6'h24;
    localparam logic [5:0] C_FN_OR    = 6'h25;
    localparam logic [5:0] C_FN_XOR   = 6'h26;

    // REGIMM rt code
    localparam logic [4:0] C_RT_BGEZAL = 5'h11;

    // Destination register select
    localparam logic [1:0] C_DST_RT = 2'd0;
    localparam logic [1:0] C_DST_RD = 2'd1;
    localparam logic [1:0] C_DST_RA = 2'd2;

    // Branch comparison select
    localparam logic [1:0] C_CMP_EQ  = 2'd0;
    localparam logic [1:0] C_CMP_NE  = 2'd1;
    localparam logic [1:0] C_CMP_GEZ = 2'd2;

    // ALU B-operand / shift select
    localparam logic [1:0] C_SRC_IMM = 2'd0;
    localparam logic [1:0] C_SRC_RT  = 2'd1;
    localparam logic [1:0] C_SRC_SLL = 2'd2;
    localparam logic [1:0] C_SRC_SRL = 2'd3;

    // HI/LO access select
    localparam logic [1:0] C_HL_MFHI = 2'd0;
    localparam logic [1:0] C_HL_MFLO = 2'd1;
    localparam logic [1:0] C_HL_MTHI = 2'd2;
    localparam logic [1:0] C_HL_MTLO = 2'd3;

    // Result-availability class
    localparam logic [1:0] C_TNEW_NONE = 2'd0;
    localparam logic [1:0] C_TNEW_ALU  = 2'd1;
    localparam logic [1:0] C_TNEW_LOAD = 2'd2;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_LUI = 3'd7
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        NPC_PC4 = 2'd0,
        NPC_J   = 2'd1,
        NPC_JR  = 2'd2
    } npc_sel_t;

    typedef enum logic [1:0] {
        DTR_ALU  = 2'd0,
        DTR_DM   = 2'd1,
        DTR_PC8  = 2'd2,
        DTR_HILO = 2'd3
    } dtr_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_M  = 2'd1,
        FWD_W  = 2'd2
    } fwd_t;

    // All-zero is a nop: no write, no memory access, no MDU activity.
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] waddr;
        logic       use_rs;
        logic       use_rt;
        logic       rs_in_d;
        logic       rt_in_d;
        logic [1:0] t_new;
        logic [1:0] reg_dst;
        npc_sel_t   npc_sel;
        logic [1:0] compare_sel;
        logic       pc_mux_sel;
        logic       ext_op;
        logic [1:0] alu_src;
        alu_ctrl_t  alu_ctrl;
        logic       is_mdu;
        logic       mdu_start;
        logic [1:0] mdu_op;
        logic [1:0] hilo_sel;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
        dtr_t       data_to_reg;
    } ctrl_bundle_t;

    // M wins over W; a load sitting in M has no data yet, so it is skipped
    // (the stall logic guarantees nobody actually needs it there).
    function automatic fwd_t fwd_pick(input logic [4:0] src,
                                      input ctrl_bundle_t m,
                                      input ctrl_bundle_t w);
        fwd_t sel;
        sel = FWD_RF;
        if (src != 5'd0) begin
            if (m.waddr == src && m.t_new != C_TNEW_LOAD) begin
                sel = FWD_M;
            end else if (w.waddr == src) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_instr_dec.sv
`default_nettype none
// ============================================================================
//  Module      : mips_instr_dec
//  Description : Combinational instruction decoder. Maps a 32-bit MIPS
//                instruction onto a ctrl_bundle_t; unsupported encodings
//                produce the all-zero nop bundle (apart from raw rs/rt).
//  Ports       : instr_i  - instruction word
//                bundle_o - decoded control bundle
//  Revision    : 1.0  initial release
// ============================================================================
module mips_instr_dec
    import mips_ctrl_pkg::*;
(
    input  logic [31:0]  instr_i,
    output ctrl_bundle_t bundle_o
);

    logic [5:0]   w_op;
    logic [4:0]   w_rs;
    logic [4:0]   w_rt;
    logic [4:0]   w_rd;
    logic [5:0]   w_fn;
    logic         w_wr;
    logic [1:0]   w_dst;
    ctrl_bundle_t w_b;
    logic         w_unused;

    assign w_op     = instr_i[31:26];
    assign w_rs     = instr_i[25:21];
    assign w_rt     = instr_i[20:16];
    assign w_rd     = instr_i[15:11];
    assign w_fn     = instr_i[5:0];
    assign w_unused = ^instr_i[10:6];   // shamt is consumed by the datapath

    always_comb begin
        w_b             = '0;
        w_b.rs          = w_rs;
        w_b.rt          = w_rt;
        w_b.npc_sel     = NPC_PC4;
        w_b.alu_ctrl    = ALU_ADD;
        w_b.data_to_reg = DTR_ALU;
        w_wr            = 1'b0;
        w_dst           = C_DST_RT;

        case (w_op)
            C_OP_SPECIAL: begin
                case (w_fn)
                    C_FN_ADD, C_FN_ADDU, C_FN_SUB, C_FN_SUBU,
                    C_FN_AND, C_FN_OR, C_FN_XOR, C_FN_MOVZ: begin
                        w_b.use_rs  = 1'b1;
                        w_b.use_rt  = 1'b1;
                        w_b.alu_src = C_SRC_RT;
                        w_wr        = 1'b1;
                        w_dst       = C_DST_RD;
                        case (w_fn)
                            C_FN_SUB, C_FN_SUBU: w_b.alu_ctrl = ALU_SUB;
                            C_FN_AND:            w_b.alu_ctrl = ALU_AND;
                            C_FN_OR:             w_b.alu_ctrl = ALU_OR;
                            C_FN_XOR:            w_b.alu_ctrl = ALU_XOR;
                            // movz only commits when rt==0, so rs+rt == rs.
                            default:             w_b.alu_ctrl = ALU_ADD;
                        endcase
                    end
                    C_FN_SLL, C_FN_SRL: begin
                        w_b.use_rt   = 1'b1;
                        w_b.alu_src  = (w_fn == C_FN_SLL) ? C_SRC_SLL : C_SRC_SRL;
                        w_b.alu_ctrl = (w_fn == C_FN_SLL) ? ALU_SLL : ALU_SRL;
                        w_wr         = 1'b1;
                        w_dst        = C_DST_RD;
                    end
                    C_FN_JR: begin
                        w_b.use_rs  = 1'b1;
                        w_b.rs_in_d = 1'b1;
                        w_b.npc_sel = NPC_JR;
                    end
                    C_FN_MFHI, C_FN_MFLO: begin
                        w_b.is_mdu      = 1'b1;
                        w_b.hilo_sel    = (w_fn == C_FN_MFHI) ? C_HL_MFHI : C_HL_MFLO;
                        w_b.data_to_reg = DTR_HILO;
                        w_wr            = 1'b1;
                        w_dst           = C_DST_RD;
                    end
                    C_FN_MTHI, C_FN_MTLO: begin
                        w_b.is_mdu   = 1'b1;
                        w_b.use_rs   = 1'b1;
                        w_b.hilo_sel = (w_fn == C_FN_MTHI) ? C_HL_MTHI : C_HL_MTLO;
                    end
                    C_FN_MULT, C_FN_MULTU, C_FN_DIV, C_FN_DIVU: begin
                        w_b.is_mdu    = 1'b1;
                        w_b.use_rs    = 1'b1;
                        w_b.use_rt    = 1'b1;
                        w_b.mdu_start = 1'b1;
                        w_b.mdu_op    = w_fn[1:0];  // 18..1b -> mult,multu,div,divu
                    end
                    default: ;
                endcase
            end
            C_OP_REGIMM: begin
                if (w_rt == C_RT_BGEZAL) begin
                    w_b.use_rs      = 1'b1;
                    w_b.rs_in_d     = 1'b1;
                    w_b.compare_sel = C_CMP_GEZ;
                    w_b.pc_mux_sel  = 1'b1;
                    w_b.ext_op      = 1'b1;
                    w_b.data_to_reg = DTR_PC8;
                    w_wr            = 1'b1;
                    w_dst           = C_DST_RA;
                end
            end
            C_OP_J: begin
                w_b.npc_sel = NPC_J;
            end
            C_OP_JAL: begin
                w_b.npc_sel     = NPC_J;
                w_b.data_to_reg = DTR_PC8;
                w_wr            = 1'b1;
                w_dst           = C_DST_RA;
            end
            C_OP_BEQ, C_OP_BNE: begin
                w_b.use_rs      = 1'b1;
                w_b.use_rt      = 1'b1;
                w_b.rs_in_d     = 1'b1;
                w_b.rt_in_d     = 1'b1;
                w_b.compare_sel = (w_op == C_OP_BEQ) ? C_CMP_EQ : C_CMP_NE;
                w_b.pc_mux_sel  = 1'b1;
                w_b.ext_op      = 1'b1;
            end
            C_OP_ADDI, C_OP_ADDIU: begin
                w_b.use_rs = 1'b1;
                w_b.ext_op = 1'b1;
                w_wr       = 1'b1;
            end
            C_OP_ORI: begin
                w_b.use_rs   = 1'b1;
                w_b.alu_ctrl = ALU_OR;
                w_wr         = 1'b1;
            end
            C_OP_LUI: begin
                w_b.alu_ctrl = ALU_LUI;
                w_wr         = 1'b1;
            end
            C_OP_LW: begin
                w_b.use_rs      = 1'b1;
                w_b.ext_op      = 1'b1;
                w_b.mem_read    = 1'b1;
                w_b.data_to_reg = DTR_DM;
                w_wr            = 1'b1;
            end
            C_OP_SW: begin
                w_b.use_rs    = 1'b1;
                w_b.use_rt    = 1'b1;
                w_b.ext_op    = 1'b1;
                w_b.mem_write = 1'b1;
            end
            default: ;
        endcase

        if (w_wr) begin
            w_b.reg_write = 1'b1;
            w_b.reg_dst   = w_dst;
            case (w_dst)
                C_DST_RD: w_b.waddr = w_rd;
                C_DST_RA: w_b.waddr = 5'd31;
                default:  w_b.waddr = w_rt;
            endcase
            w_b.t_new = w_b.mem_read ? C_TNEW_LOAD : C_TNEW_ALU;
        end
    end

    assign bundle_o = w_b;

endmodule
`default_nettype wire

// File: rtl/mips_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pipe_ctrl
//  Description : Pipeline controller for the five-stage MIPS core. Decodes D,
//                carries control bundles through E/M/W, detects load-use,
//                branch and MDU hazards, and produces forwarding selects.
//  Ports       : clk, rst_n (async, active-low), instr_d (D instruction)
//                stall            - hold PC/IF-ID, bubble into E
//                *_d              - combinational D-stage decode
//                *_e, *_m, *_w    - registered per-stage controls
//                fwd_{rs,rt}_{d,e}- 0 RF/pipe, 1 M result, 2 W result
//  Revision    : 1.0  initial release
// ============================================================================
module mips_pipe_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_d,
    output logic        stall,
    output logic [1:0]  reg_dst_d,
    output logic [1:0]  npc_sel_d,
    output logic [1:0]  compare_sel_d,
    output logic        pc_mux_sel_d,
    output logic        ext_op_d,
    output logic [1:0]  alu_src_e,
    output logic [2:0]  alu_ctrl_e,
    output logic        mdu_start_e,
    output logic [1:0]  mdu_op_e,
    output logic [1:0]  hilo_sel_e,
    output logic        mem_write_m,
    output logic        mem_read_m,
    output logic        reg_write_w,
    output logic [1:0]  data_to_reg_w,
    output logic [4:0]  waddr_e,
    output logic [4:0]  waddr_m,
    output logic [4:0]  waddr_w,
    output logic [1:0]  fwd_rs_d,
    output logic [1:0]  fwd_rt_d,
    output logic [1:0]  fwd_rs_e,
    output logic [1:0]  fwd_rt_e
);

    localparam logic [CNT_W-1:0] C_MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] C_DIV_LOAD = CNT_W'(DIV_LAT - 1);

    ctrl_bundle_t     w_dec;
    ctrl_bundle_t     e_q, e_d;
    ctrl_bundle_t     m_q;
    ctrl_bundle_t     w_q;
    logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;

    logic w_load_use;
    logic w_branch_rs;
    logic w_branch_rt;
    logic w_mdu_stall;
    logic w_unused;

    mips_instr_dec u_dec (
        .instr_i  (instr_d),
        .bundle_o (w_dec)
    );

    // ---------------------------------------------------------------- hazards
    always_comb begin
        w_load_use = (e_q.t_new == C_TNEW_LOAD) && (e_q.waddr != 5'd0) &&
                     ((w_dec.use_rs && w_dec.rs == e_q.waddr) ||
                      (w_dec.use_rt && w_dec.rt == e_q.waddr));

        // Operand compared in D: any producer in E, or a load still in M.
        w_branch_rs = w_dec.rs_in_d && (w_dec.rs != 5'd0) &&
                      ((e_q.waddr == w_dec.rs && e_q.t_new != C_TNEW_NONE) ||
                       (m_q.waddr == w_dec.rs && m_q.t_new == C_TNEW_LOAD));
        w_branch_rt = w_dec.rt_in_d && (w_dec.rt != 5'd0) &&
                      ((e_q.waddr == w_dec.rt && e_q.t_new != C_TNEW_NONE) ||
                       (m_q.waddr == w_dec.rt && m_q.t_new == C_TNEW_LOAD));

        w_mdu_stall = w_dec.is_mdu && (e_q.mdu_start || busy_cnt_q != '0);

        stall = w_load_use || w_branch_rs || w_branch_rt || w_mdu_stall;
    end

    // ------------------------------------------------------------- next state
    always_comb begin
        e_d = stall ? ctrl_bundle_t'('0) : w_dec;

        busy_cnt_d = busy_cnt_q;
        if (e_q.mdu_start) begin
            busy_cnt_d = e_q.mdu_op[1] ? C_DIV_LOAD : C_MUL_LOAD;
        end else if (busy_cnt_q != '0) begin
            busy_cnt_d = busy_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q        <= '0;
            m_q        <= '0;
            w_q        <= '0;
            busy_cnt_q <= '0;
        end else begin
            e_q        <= e_d;
            m_q        <= e_q;
            w_q        <= m_q;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign reg_dst_d     = w_dec.reg_dst;
    assign npc_sel_d     = w_dec.npc_sel;
    assign compare_sel_d = w_dec.compare_sel;
    assign pc_mux_sel_d  = w_dec.pc_mux_sel;
    assign ext_op_d      = w_dec.ext_op;

    assign alu_src_e     = e_q.alu_src;
    assign alu_ctrl_e    = e_q.alu_ctrl;
    assign mdu_start_e   = e_q.mdu_start;
    assign mdu_op_e      = e_q.mdu_op;
    assign hilo_sel_e    = e_q.hilo_sel;
    assign waddr_e       = e_q.waddr;

    assign mem_write_m   = m_q.mem_write;
    assign mem_read_m    = m_q.mem_read;
    assign waddr_m       = m_q.waddr;

    assign reg_write_w   = w_q.reg_write;
    assign data_to_reg_w = w_q.data_to_reg;
    assign waddr_w       = w_q.waddr;

    assign fwd_rs_d      = fwd_pick(w_dec.rs, m_q, w_q);
    assign fwd_rt_d      = fwd_pick(w_dec.rt, m_q, w_q);
    assign fwd_rs_e      = fwd_pick(e_q.rs, m_q, w_q);
    assign fwd_rt_e      = fwd_pick(e_q.rt, m_q, w_q);

    // Bundle fields that only matter in other stages.
    assign w_unused = ^{w_dec, e_q, m_q, w_q};

endmodule
`default_nettype wire

// File: tb/tb_mips_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_pipe_ctrl
//  Description : Directed self-checking bench for mips_pipe_ctrl. Inputs are
//                applied on the falling edge, outputs sampled 1 time unit
//                later, so each "cycle" below is one D-stage occupancy.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_pipe_ctrl;

    localparam logic [5:0] OP_REGIMM = 6'h01, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ORI = 6'h0d, OP_LW = 6'h23,
                           OP_SW = 6'h2b;
    localparam logic [5:0] FN_JR = 6'h08, FN_MFLO = 6'h12, FN_MULT = 6'h18,
                           FN_DIV = 6'h1a, FN_ADDU = 6'h21;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_d;
    wire         stall, pc_mux_sel_d, ext_op_d, mdu_start_e;
    wire         mem_write_m, mem_read_m, reg_write_w;
    wire  [1:0]  reg_dst_d, npc_sel_d, compare_sel_d, alu_src_e, mdu_op_e;
    wire  [1:0]  hilo_sel_e, data_to_reg_w;
    wire  [2:0]  alu_ctrl_e;
    wire  [4:0]  waddr_e, waddr_m, waddr_w;
    wire  [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    wire  [29:0] regs_o;

    int checks = 0;
    int errors = 0;

    mips_pipe_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .stall(stall),
        .reg_dst_d(reg_dst_d), .npc_sel_d(npc_sel_d),
        .compare_sel_d(compare_sel_d), .pc_mux_sel_d(pc_mux_sel_d),
        .ext_op_d(ext_op_d), .alu_src_e(alu_src_e), .alu_ctrl_e(alu_ctrl_e),
        .mdu_start_e(mdu_start_e), .mdu_op_e(mdu_op_e),
        .hilo_sel_e(hilo_sel_e), .mem_write_m(mem_write_m),
        .mem_read_m(mem_read_m), .reg_write_w(reg_write_w),
        .data_to_reg_w(data_to_reg_w), .waddr_e(waddr_e), .waddr_m(waddr_m),
        .waddr_w(waddr_w), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e)
    );

    always #5 clk = ~clk;

    assign regs_o = {waddr_e, waddr_m, waddr_w, reg_write_w, mem_write_m,
                     mem_read_m, mdu_start_e, alu_ctrl_e, alu_src_e,
                     hilo_sel_e, mdu_op_e, data_to_reg_w};

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic set_d(input logic [31:0] i);
        @(negedge clk);
        instr_d = i;
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 12; k++) set_d(32'd0);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        instr_d = 32'd0;
        #12;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall); end
        checks++; if (regs_o !== 30'd0) begin errors++; $display("FAIL reset_regs: got %h want 0", regs_o); end
        @(negedge clk);
        rst_n = 1'b1;
        drain();
    endtask

    task automatic test_decode();
        set_d(rtype(5'd1, 5'd2, 5'd3, FN_ADDU));
        checks++; if ({reg_dst_d, npc_sel_d, pc_mux_sel_d} !== 5'b01_00_0) begin errors++; $display("FAIL dec_addu: got %b want 01000", {reg_dst_d, npc_sel_d, pc_mux_sel_d}); end
        set_d(itype(OP_ORI, 5'd0, 5'd8, 16'd1));
        checks++; if ({ext_op_d, reg_dst_d} !== 3'b0_00) begin errors++; $display("FAIL dec_ori: got %b want 000", {ext_op_d, reg_dst_d}); end
        set_d(itype(OP_BNE, 5'd9, 5'd10, 16'd4));
        checks++; if ({compare_sel_d, pc_mux_sel_d, ext_op_d, stall} !== 5'b01_1_1_0) begin errors++; $display("FAIL dec_bne: got %b want 01110", {compare_sel_d, pc_mux_sel_d, ext_op_d, stall}); end
        checks++; if ({waddr_e, alu_ctrl_e, alu_src_e} !== {5'd8, 3'd3, 2'd0}) begin errors++; $display("FAIL ori_in_e: got %h want %h", {waddr_e, alu_ctrl_e, alu_src_e}, {5'd8, 3'd3, 2'd0}); end
        set_d(itype(OP_REGIMM, 5'd11, 5'h11, 16'd8));
        checks++; if ({compare_sel_d, reg_dst_d} !== 4'b10_10) begin errors++; $display("FAIL dec_bgezal: got %b want 1010", {compare_sel_d, reg_dst_d}); end
        set_d(32'hFC22_0010);   // unsupported opcode 0x3f
        checks++; if ({npc_sel_d, pc_mux_sel_d, reg_dst_d, ext_op_d} !== 6'd0) begin errors++; $display("FAIL dec_illegal: got %b want 0", {npc_sel_d, pc_mux_sel_d, reg_dst_d, ext_op_d}); end
        set_d(32'd0);
        checks++; if ({waddr_e, waddr_m} !== {5'd0, 5'd31}) begin errors++; $display("FAIL illegal_nop: got %h want %h", {waddr_e, waddr_m}, {5'd0, 5'd31}); end
        drain();
    endtask

    task automatic test_load_use();
        set_d(itype(OP_LW, 5'd0, 5'd1, 16'd0));
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_lw_nostall: got %0b want 0", stall); end
        set_d(rtype(5'd1, 5'd1, 5'd2, FN_ADDU));
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0b want 1", stall); end
        set_d(rtype(5'd1, 5'd1, 5'd2, FN_ADDU));
        checks++; if ({stall, waddr_e, mem_read_m} !== {1'b0, 5'd0, 1'b1}) begin errors++; $display("FAIL lu_bubble: got %h want %h", {stall, waddr_e, mem_read_m}, {1'b0, 5'd0, 1'b1}); end
        set_d(32'd0);
        checks++; if ({fwd_rs_e, fwd_rt_e} !== 4'b10_10) begin errors++; $display("FAIL lu_fwd_e: got %b want 1010", {fwd_rs_e, fwd_rt_e}); end
        checks++; if ({waddr_e, reg_write_w, data_to_reg_w, waddr_w} !== {5'd2, 1'b1, 2'd1, 5'd1}) begin errors++; $display("FAIL lu_wb: got %h want %h", {waddr_e, reg_write_w, data_to_reg_w, waddr_w}, {5'd2, 1'b1, 2'd1, 5'd1}); end
        drain();
    endtask

    task automatic test_branch_alu();
        set_d(rtype(5'd4, 5'd5, 5'd3, FN_ADDU));
        set_d(itype(OP_BEQ, 5'd3, 5'd0, 16'd4));
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL br_alu_stall: got %0b want 1", stall); end
        set_d(itype(OP_BEQ, 5'd3, 5'd0, 16'd4));
        checks++; if ({stall, fwd_rs_d, fwd_rt_d} !== 5'b0_01_00) begin errors++; $display("FAIL br_alu_fwd: got %b want 00100", {stall, fwd_rs_d, fwd_rt_d}); end
        set_d(itype(OP_ORI, 5'd0, 5'd8, 16'd1));   // delay slot
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL br_slot_stall: got %0b want 0", stall); end
        set_d(32'd0);
        checks++; if (waddr_e !== 5'd8) begin errors++; $display("FAIL br_slot_in_e: got %0d want 8", waddr_e); end
        drain();
    endtask

    task automatic test_branch_load();
        set_d(itype(OP_LW, 5'd0, 5'd7, 16'd4));
        set_d(itype(OP_BEQ, 5'd7, 5'd0, 16'd4));
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL br_ld_stall1: got %0b want 1", stall); end
        set_d(itype(OP_BEQ, 5'd7, 5'd0, 16'd4));
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL br_ld_stall2: got %0b want 1", stall); end
        set_d(itype(OP_BEQ, 5'd7, 5'd0, 16'd4));
        checks++; if ({stall, fwd_rs_d} !== 3'b0_10) begin errors++; $display("FAIL br_ld_fwd: got %b want 010", {stall, fwd_rs_d}); end
        drain();
    endtask

    task automatic test_mdu(input logic [5:0] fn, input int exp_n, input logic [1:0] exp_op);
        int n;
        set_d(rtype(5'd1, 5'd2, 5'd0, fn));
        set_d(rtype(5'd0, 5'd0, 5'd3, FN_MFLO));
        checks++; if ({stall, mdu_start_e, mdu_op_e} !== {2'b11, exp_op}) begin errors++; $display("FAIL mdu_start: got %b want %b", {stall, mdu_start_e, mdu_op_e}, {2'b11, exp_op}); end
        n = 1;
        while (n < 40) begin
            set_d(rtype(5'd0, 5'd0, 5'd3, FN_MFLO));
            if (!stall) break;
            n++;
        end
        checks++; if (n !== exp_n) begin errors++; $display("FAIL mdu_stall_len: got %0d want %0d", n, exp_n); end
        set_d(32'd0);
        checks++; if ({waddr_e, hilo_sel_e, mdu_start_e} !== {5'd3, 2'd1, 1'b0}) begin errors++; $display("FAIL mflo_in_e: got %h want %h", {waddr_e, hilo_sel_e, mdu_start_e}, {5'd3, 2'd1, 1'b0}); end
        drain();
    endtask

    task automatic test_zero_reg();
        set_d(rtype(5'd1, 5'd2, 5'd0, FN_ADDU));
        set_d(rtype(5'd0, 5'd0, 5'd4, FN_ADDU));
        checks++; if ({stall, fwd_rs_d, fwd_rt_d, waddr_e} !== 10'd0) begin errors++; $display("FAIL zero_d: got %b want 0", {stall, fwd_rs_d, fwd_rt_d, waddr_e}); end
        set_d(32'd0);
        checks++; if ({fwd_rs_e, fwd_rt_e} !== 4'd0) begin errors++; $display("FAIL zero_e: got %b want 0", {fwd_rs_e, fwd_rt_e}); end
        drain();
    endtask

    task automatic test_back_to_back();
        set_d(rtype(5'd1, 5'd2, 5'd5, FN_ADDU));
        set_d(rtype(5'd3, 5'd4, 5'd5, FN_ADDU));
        set_d(rtype(5'd5, 5'd5, 5'd6, FN_ADDU));
        checks++; if ({stall, fwd_rs_d, fwd_rt_d} !== 5'b0_01_01) begin errors++; $display("FAIL b2b_d: got %b want 00101", {stall, fwd_rs_d, fwd_rt_d}); end
        set_d(32'd0);
        checks++; if ({fwd_rs_e, fwd_rt_e, waddr_m, waddr_w} !== {4'b01_01, 5'd5, 5'd5}) begin errors++; $display("FAIL b2b_m_wins: got %h want %h", {fwd_rs_e, fwd_rt_e, waddr_m, waddr_w}, {4'b01_01, 5'd5, 5'd5}); end
        drain();
    endtask

    task automatic test_jal_fwd();
        set_d({OP_JAL, 26'h10});
        checks++; if ({npc_sel_d, reg_dst_d} !== 4'b01_10) begin errors++; $display("FAIL jal_dec: got %b want 0110", {npc_sel_d, reg_dst_d}); end
        set_d(32'd0);
        set_d(rtype(5'd31, 5'd0, 5'd0, FN_JR));
        checks++; if ({stall, fwd_rs_d, npc_sel_d} !== 5'b0_01_10) begin errors++; $display("FAIL jr_fwd_pc8: got %b want 00110", {stall, fwd_rs_d, npc_sel_d}); end
        set_d(32'd0);
        checks++; if ({data_to_reg_w, waddr_w} !== {2'd2, 5'd31}) begin errors++; $display("FAIL jal_wb: got %h want %h", {data_to_reg_w, waddr_w}, {2'd2, 5'd31}); end
        drain();
    endtask

    task automatic test_store();
        set_d(itype(OP_SW, 5'd1, 5'd2, 16'd8));
        set_d(32'd0);
        set_d(32'd0);
        checks++; if ({mem_write_m, mem_read_m, waddr_m} !== {2'b10, 5'd0}) begin errors++; $display("FAIL sw_m: got %b want 1000000", {mem_write_m, mem_read_m, waddr_m}); end
        drain();
    endtask

    task automatic test_reset_mid_div();
        set_d(rtype(5'd1, 5'd2, 5'd0, FN_DIV));
        set_d(rtype(5'd0, 5'd0, 5'd3, FN_MFLO));
        set_d(rtype(5'd0, 5'd0, 5'd3, FN_MFLO));
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL div_busy_stall: got %0b want 1", stall); end
        rst_n = 1'b0;
        #1;
        checks++; if ({stall, regs_o} !== 31'd0) begin errors++; $display("FAIL mid_reset_clear: got %h want 0", {stall, regs_o}); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL post_reset_stall: got %0b want 0", stall); end
        set_d(32'd0);
        checks++; if ({waddr_e, hilo_sel_e} !== {5'd3, 2'd1}) begin errors++; $display("FAIL post_reset_mflo: got %h want %h", {waddr_e, hilo_sel_e}, {5'd3, 2'd1}); end
        drain();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_load_use();
        test_branch_alu();
        test_branch_load();
        test_mdu(FN_MULT, 5, 2'd0);
        test_mdu(FN_DIV, 10, 2'd2);
        test_zero_reg();
        test_back_to_back();
        test_jal_fwd();
        test_store();
        test_reset_mid_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
